// File: rtl/perf_counter_unit.sv
// -----------------------------------------------------------------------------
// perf_counter_unit
//
// Purpose:
//   Performance-measurement block. It holds one free-running cycle counter and
//   NUM_EVT event counters, all gated by a three-state run controller
//   (IDLE -> RUN -> DONE). A run starts on start_i. It ends by itself after
//   MAX_CYCLES counted cycles, or never when MAX_CYCLES is 0. Any counter can
//   be read back through a registered read mux.
//
// Configuration macro:
//   PERF_SATURATE_EN - when defined, counters stick at all-ones instead of
//                      wrapping. The sticky overflow flag behaves the same in
//                      both builds.
//
// Ports:
//   clk_i      in   1          rising-edge clock
//   rst_i      in   1          synchronous, active-high reset
//   start_i    in   1          begins a run from IDLE (level)
//   clr_i      in   1          clears counters and flags; returns to IDLE
//   evt_i      in   NUM_EVT    per-channel event strobe
//   inhibit_i  in   NUM_EVT    per-channel event suppression
//   rd_sel_i   in   SEL_W      0 = cycle counter, k = event channel k-1
//   rd_data_o  out  CNT_W      registered read data (one cycle latency)
//   cycle_o    out  CNT_W      live cycle counter
//   running_o  out  1          high in RUN
//   done_o     out  1          high in DONE
//   ovf_o      out  NUM_EVT+1  sticky overflow; bit 0 = cycle, bit k = chan k-1
// -----------------------------------------------------------------------------
module perf_counter_unit #(
  parameter int NUM_EVT    = 4,
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 64,
  parameter int SEL_W      = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               clr_i,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic [NUM_EVT-1:0] inhibit_i,
  input  logic [SEL_W-1:0]   rd_sel_i,
  output logic [CNT_W-1:0]   rd_data_o,
  output logic [CNT_W-1:0]   cycle_o,
  output logic               running_o,
  output logic               done_o,
  output logic [NUM_EVT:0]   ovf_o
);

  // Cycle-counter value on the last counted cycle of a limited run.
  localparam logic [CNT_W-1:0] TERM_VAL = CNT_W'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  state_e             state_q;
  state_e             state_d;
  logic [CNT_W-1:0]   cycle_q;
  logic [CNT_W-1:0]   evt_cnt_q [NUM_EVT];
  logic [NUM_EVT:0]   ovf_q;
  logic [CNT_W-1:0]   rd_data_q;
  logic [CNT_W-1:0]   rd_mux;
  logic [NUM_EVT-1:0] evt_qual;
  logic               terminal;

  // Next counter value. The saturating build holds at all-ones. The caller
  // detects the overflow attempt separately, so the flag logic is the same
  // in both builds.
  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
`ifdef PERF_SATURATE_EN
    return (&v) ? v : v + 1'b1;
`else
    return v + 1'b1;
`endif
  endfunction

  assign evt_qual = evt_i & ~inhibit_i;
  assign terminal = (MAX_CYCLES != 0) && (cycle_q == TERM_VAL);

  // ---------------------------------------------------------------------------
  // Run controller
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: defaulting every always_comb output first keeps all paths assigned
    // and prevents latch inference.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start_i)  state_d = ST_RUN;
      ST_RUN:  if (terminal) state_d = ST_DONE;
      ST_DONE: state_d = ST_DONE;   // only clr/rst leave DONE
      default: state_d = ST_IDLE;
    endcase
    // Clear wins over start and over the terminal transition.
    if (clr_i) state_d = ST_IDLE;
  end

  // ---------------------------------------------------------------------------
  // Counters and sticky overflow flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cycle_q <= '0;
      // NOTE: the counter array is built from flops, not a RAM macro, so it can
      // and must be reset like any other state register.
      for (int k = 0; k < NUM_EVT; k++) evt_cnt_q[k] <= '0;
      ovf_q <= '0;
    end else if (state_q == ST_RUN) begin
      cycle_q <= bump(cycle_q);
      if (&cycle_q) ovf_q[0] <= 1'b1;
      for (int k = 0; k < NUM_EVT; k++) begin
        if (evt_qual[k]) begin
          evt_cnt_q[k] <= bump(evt_cnt_q[k]);
          if (&evt_cnt_q[k]) ovf_q[k+1] <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read-back mux. It uses pre-edge counter state and is registered once.
  // Selects above NUM_EVT read as zero.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_mux = '0;
    if (rd_sel_i == '0) rd_mux = cycle_q;
    for (int k = 0; k < NUM_EVT; k++) begin
      if (rd_sel_i == SEL_W'(k + 1)) rd_mux = evt_cnt_q[k];
    end
  end

  // Clear does not touch the read register: it shows the counter values from
  // before the clearing edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) rd_data_q <= '0;
    else       rd_data_q <= rd_mux;
  end

  assign rd_data_o = rd_data_q;
  assign cycle_o   = cycle_q;
  assign ovf_o     = ovf_q;
  assign running_o = (state_q == ST_RUN);
  assign done_o    = (state_q == ST_DONE);

endmodule

// File: doc/perf_counter_unit.md
PERF_COUNTER_UNIT -- requirements
Module: perf_counter_unit

Interface
REQ-001 Parameter NUM_EVT, default 4: number of event counter channels (1..16).
REQ-002 Parameter CNT_W, default 32: width of every counter (8..64).
REQ-003 Parameter MAX_CYCLES, default 64: run length in cycles; 0 = unlimited.
REQ-004 Parameter SEL_W, default 3: rd_sel_i width; SHALL be at least ceil(log2(NUM_EVT+1)).
REQ-005 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-006 rst_i  in  1  reset, synchronous, active-high.
REQ-007 start_i  in  1  level; begins a measurement run from IDLE.
REQ-008 clr_i  in  1  clears counters, flags and state to IDLE.
REQ-009 evt_i  in  NUM_EVT  per-channel event strobe, one count per cycle high.
REQ-010 inhibit_i  in  NUM_EVT  per-channel qualifier; event k is not counted while inhibit_i[k]=1 (e.g. stall suppressed during branch).
REQ-011 rd_sel_i  in  SEL_W  read select: 0 = cycle counter, k = event channel k-1.
REQ-012 rd_data_o  out  CNT_W  registered read data.
REQ-013 cycle_o  out  CNT_W  live cycle counter.
REQ-014 running_o  out  1  high in RUN state.
REQ-015 done_o  out  1  high in DONE state.
REQ-016 ovf_o  out  NUM_EVT+1  sticky overflow flags; bit 0 = cycle counter, bit k = channel k-1.

Function
REQ-017 FSM states IDLE, RUN, DONE; IDLE->RUN when start_i=1; RUN->DONE on terminal cycle; DONE->IDLE only via clr_i or rst_i.
REQ-018 In RUN each cycle: cycle counter +1; channel k +1 iff evt_i[k]=1 and inhibit_i[k]=0.
REQ-019 The start cycle (IDLE with start_i=1) is not counted; first count on the first RUN cycle.
REQ-020 Terminal cycle: RUN with cycle counter == MAX_CYCLES-1; that cycle and its events are counted, cycle counter ends at MAX_CYCLES, next state DONE.
REQ-021 MAX_CYCLES=0: RUN never terminates.
REQ-022 IDLE and DONE: all counters hold; evt_i ignored.
REQ-023 start_i in RUN or DONE: ignored.
REQ-024 clr_i: next cycle all counters 0, ovf_o 0, state IDLE; clr_i has priority over start_i and over the terminal transition.
REQ-025 Counters wrap modulo 2^CNT_W; increment from all-ones sets the matching ovf_o bit, which stays set until clr_i/rst_i.
REQ-026 rd_data_o = value of selected counter as of the previous edge's register state, one cycle latency; rd_sel_i > NUM_EVT returns 0.
REQ-027 running_o, done_o are decoded directly from the registered state.

Reset
REQ-028 rst_i=1 at an edge: state IDLE, all counters 0, ovf_o 0, rd_data_o 0, running_o 0, done_o 0.
REQ-029 rst_i has priority over clr_i, start_i and all events, including mid-run.
REQ-030 After rst_i deasserts, start_i is honoured on the first edge.

Configuration
REQ-031 Macro PERF_SATURATE_EN: when defined, counters saturate at all-ones instead of wrapping; ovf_o bit still sets on the first attempted increment past all-ones.
REQ-032 Without PERF_SATURATE_EN: wrap behaviour per REQ-025.

Verification
REQ-033 Defaults; rst, start_i 1 cycle, evt_i[0]=1 constantly -> done_o after 64 RUN cycles, cycle_o=64, channel 0 = 64.
REQ-034 evt_i[1]=1 for 10 cycles, inhibit_i[1]=1 on 3 of them -> channel 1 = 7; rd_sel_i=2 -> rd_data_o=7 one cycle later.
REQ-035 CNT_W=8, MAX_CYCLES=0, evt_i[0]=1 for 300 cycles -> channel 0 = 44, ovf_o[1]=1 (wrap); with PERF_SATURATE_EN -> 255, ovf_o[1]=1.
REQ-036 clr_i and start_i together at cycle 20 of a run -> next cycle IDLE, all counters 0, running_o=0.
REQ-037 rst_i at cycle 30 of a run -> next cycle all outputs 0; fresh start_i -> counts restart from 0.
REQ-038 rd_sel_i=7 with NUM_EVT=4 -> rd_data_o=0; start_i during DONE -> state stays DONE.
